// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial byte receiver.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    STOP_CHK,
    LOAD
  } rx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: the first strobe arrives after half a bit period (start-bit
// centre), and each later strobe arrives one full bit period after the previous one.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic restart,
  output logic sample_strobe
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;

  assign sample_strobe = enable && (cnt_q == (first_q ? HALF_LAST : FULL_LAST));

  always_comb begin
    cnt_d   = cnt_q;
    first_d = first_q;
    if (restart || !enable) begin
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (sample_strobe) begin
      cnt_d   = '0;
      first_d = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/serial_byte_rx.sv
// Serial-to-parallel byte receiver with start-glitch rejection, stop-bit check
// and a ready/read handoff carrying framing and overrun flags.
module serial_byte_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output rx_state_t            dbg_state
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, prev_q;
  logic [DATA_BITS-1:0] shift_q, rx_data_q;
  logic                 ready_q, overrun_q, framing_q;
  logic [BCW-1:0]       bit_cnt_q;
  rx_state_t            state_q;
  logic                 fall, timer_en, strobe;

  assign fall     = prev_q & ~sync2_q;
  assign timer_en = (state_q == START_CHK) || (state_q == DATA) || (state_q == STOP_CHK);

  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (timer_en),
    .restart      ((state_q == IDLE) && fall),
    .sample_strobe(strobe)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      prev_q  <= IDLE_LEVEL;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Handshake: data_ready high means rx_data holds an unread byte; data_read high
  // while data_ready is high consumes it on the next edge. A load on the same edge
  // wins, so the new byte stays pending and the overrun flag is cleared.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q   <= '1;
      rx_data_q <= '1;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
      bit_cnt_q <= '0;
      state_q   <= IDLE;
    end else begin
      if (data_read) begin
        ready_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (fall) begin
          framing_q <= 1'b0;
          state_q   <= START_CHK;
        end
        START_CHK: if (strobe) begin
          bit_cnt_q <= '0;
          state_q   <= (sync2_q == IDLE_LEVEL) ? IDLE : DATA;
        end
        DATA: if (strobe) begin
          shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) state_q <= STOP_CHK;
          else bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        STOP_CHK: if (strobe) begin
          // Outputs update on the edge entering LOAD so the byte is visible
          // the cycle right after the stop sample.
          if (sync2_q == IDLE_LEVEL) begin
            rx_data_q <= shift_q;
            ready_q   <= 1'b1;
            overrun_q <= ready_q & ~data_read;
            state_q   <= LOAD;
          end else begin
            framing_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        LOAD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = ready_q;
  assign overrun_error = overrun_q;
  assign framing_error = framing_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx: frames are driven bit by bit with a 10-clock
// bit period and outputs are checked against hand-derived values.
module tb_serial_byte_rx;
  import serial_rx_pkg::*;

  localparam int C = 10;

  logic      clk = 1'b0;
  logic      n_rst = 1'b0;
  logic      serial_in = 1'b1;
  logic      data_read = 1'b0;
  logic [7:0] rx_data;
  logic      data_ready, overrun_error, framing_error;
  rx_state_t dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  int bad    = 0;

  serial_byte_rx #(.DATA_BITS(8), .CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .data_read    (data_read),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives data and stop bits, assuming a full start bit was already driven.
  // Byte lands on the edge 8 cycles into the stop bit; rd_at_load asserts
  // data_read for exactly the cycle before that edge.
  task automatic send_rest(input logic [7:0] d, input logic stop, input logic rd_at_load);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      tick(C);
    end
    serial_in = stop;
    tick(7);
    data_read = rd_at_load;
    tick(1);
    data_read = 1'b0;
    tick(2);
    serial_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_at_load);
    serial_in = 1'b0;
    tick(C);
    send_rest(d, stop, rd_at_load);
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
  endtask

  initial begin
    // Reset values, then a quiet idle line must leave everything untouched.
    tick(2);
    check("rst_rx_data", rx_data, 8'hFF);
    check("rst_ready", data_ready, 1'b0);
    check("rst_overrun", overrun_error, 1'b0);
    check("rst_framing", framing_error, 1'b0);
    check("rst_state", dbg_state, IDLE);
    n_rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (dbg_state !== IDLE || data_ready !== 1'b0 || rx_data !== 8'hFF) bad++;
    end
    check("idle_quiet", bad, 0);

    // 0xA5: t0 is two cycles after the line falls; the byte is visible at t0+96.
    serial_in = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      serial_in = (i == 0 || i == 2 || i == 5 || i == 7);
      tick(C);
    end
    serial_in = 1'b1;
    tick(7);
    check("a5_not_yet", data_ready, 1'b0);
    tick(1);
    check("a5_ready", data_ready, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_framing", framing_error, 1'b0);
    check("a5_overrun", overrun_error, 1'b0);
    tick(4);
    read_pulse();
    check("a5_read_clr", data_ready, 1'b0);
    check("a5_data_kept", rx_data, 8'hA5);
    tick(5);

    // 0x3C with a bad stop bit.
    send_frame(8'h3C, 1'b0, 1'b0);
    check("fe_set", framing_error, 1'b1);
    check("fe_ready", data_ready, 1'b0);
    check("fe_data_kept", rx_data, 8'hA5);
    tick(5);

    // 0x5A: framing_error holds until the edge ending t0.
    serial_in = 1'b0;
    tick(2);
    check("fe_held_pre_t0", framing_error, 1'b1);
    tick(1);
    check("fe_clr_at_t0", framing_error, 1'b0);
    tick(C - 3);
    send_rest(8'h5A, 1'b1, 1'b0);
    check("5a_data", rx_data, 8'h5A);
    check("5a_ready", data_ready, 1'b1);
    check("5a_framing", framing_error, 1'b0);
    read_pulse();
    check("5a_read_clr", data_ready, 1'b0);
    tick(5);

    // Three-cycle glitch: rejected at the start-bit sample.
    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(1);
    check("gl_start_chk", dbg_state, START_CHK);
    tick(4);
    check("gl_back_idle", dbg_state, IDLE);
    check("gl_data", rx_data, 8'h5A);
    check("gl_ready", data_ready, 1'b0);
    check("gl_framing", framing_error, 1'b0);
    tick(10);
    send_frame(8'h81, 1'b1, 1'b0);
    check("81_data", rx_data, 8'h81);
    check("81_ready", data_ready, 1'b1);
    check("81_framing", framing_error, 1'b0);
    read_pulse();
    tick(3);

    // Back-to-back frames without a read.
    send_frame(8'h11, 1'b1, 1'b0);
    check("ov_first_data", rx_data, 8'h11);
    check("ov_first_flag", overrun_error, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ov_data", rx_data, 8'h22);
    check("ov_ready", data_ready, 1'b1);
    check("ov_flag", overrun_error, 1'b1);
    read_pulse();
    check("ov_read_ready", data_ready, 1'b0);
    check("ov_read_flag", overrun_error, 1'b0);

    // Read coincident with the second load: load wins, no overrun.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    check("co_flag", overrun_error, 1'b0);
    check("co_ready", data_ready, 1'b1);
    check("co_data", rx_data, 8'h22);
    tick(3);

    // Asynchronous reset during data bit 4 of a frame.
    serial_in = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      serial_in = i[0];
      tick(C);
    end
    serial_in = 1'b0;
    tick(3);
    #2;
    n_rst = 1'b0;
    #1;
    check("ar_rx_data", rx_data, 8'hFF);
    check("ar_ready", data_ready, 1'b0);
    check("ar_overrun", overrun_error, 1'b0);
    check("ar_framing", framing_error, 1'b0);
    check("ar_state", dbg_state, IDLE);
    serial_in = 1'b1;
    tick(3);
    n_rst = 1'b1;
    tick(C + 5);
    check("ar_quiet", data_ready, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    check("7e_data", rx_data, 8'h7E);
    check("7e_ready", data_ready, 1'b1);
    check("7e_framing", framing_error, 1'b0);
    check("7e_overrun", overrun_error, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
